// File: rtl/pkt_fifo_reader_pkg.sv
// Shared definitions for the packet FIFO reader: header layout and FSM states.
package pkt_fifo_reader_pkg;

  // Header byte layout: [7:6] destination port, [5:0] payload length.
  localparam int unsigned HDR_PORT_MSB = 7;
  localparam int unsigned HDR_PORT_LSB = 6;
  localparam int unsigned HDR_LEN_MSB  = 5;

  typedef struct packed {
    logic [HDR_PORT_MSB-HDR_PORT_LSB:0] port;
    logic [HDR_LEN_MSB:0]               len;
  } hdr_t;

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } rd_state_t;

endpackage

// File: rtl/pkt_fifo_reader_if.sv
// Framed payload stream from the FIFO reader towards the crossbar.
interface pkt_fifo_reader_if #(
  parameter int unsigned DATA   = 8,
  parameter int unsigned PORT_W = 2
);
  logic [DATA-1:0]   out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic [PORT_W-1:0] out_port;
  logic              out_ready;

  modport master (
    output out_data, out_valid, out_sop, out_eop, out_port,
    input  out_ready
  );

  modport slave (
    input  out_data, out_valid, out_sop, out_eop, out_port,
    output out_ready
  );
endinterface

// File: rtl/pkt_fifo_reader_skid.sv
// Two-entry register buffer between the FIFO read port and the packet FSM.
// head is entry 0; cnt is the number of valid entries (0..2).
module skid_buf2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   cnt
);
  logic [W-1:0] e0;
  logic [W-1:0] e1;
  logic         do_pop;
  logic         do_push;

  // Ignore pops of an empty buffer and pushes into a full one that is not draining.
  always_comb begin
    do_pop  = pop && (cnt != 2'd0);
    do_push = push && ((cnt != 2'd2) || do_pop);
    head    = e0;
  end

  // Storage and occupancy; a simultaneous push/pop keeps the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/pkt_fifo_reader.sv
// Pops header+payload packets from the input byte FIFO and forwards the
// payload as framed beats (sop/eop/port) with valid/ready backpressure.
module pkt_fifo_reader
  import pkt_fifo_reader_pkg::*;
#(
  parameter int unsigned DATA   = 8,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned PORT_W = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA-1:0]   fifo_read_data,
  input  logic              fifo_read_data_valid,
  input  logic              fifo_empty,
  output logic              fifo_read_req,
  pkt_fifo_reader_if.master out_if,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);
  rd_state_t         state;
  logic              first;
  logic [LEN_W-1:0]  remaining;
  logic [PORT_W-1:0] port_q;
  logic              inflight;

  logic [1:0]        buf_cnt;
  logic [DATA-1:0]   buf_head;
  logic              buf_has;
  logic              buf_pop;
  logic              hdr_pop;
  logic              xfer;
  logic              valid_c;
  logic [2:0]        level;
  hdr_t              hdr;

  skid_buf2 #(.W(DATA)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_read_data_valid),
    .push_data (fifo_read_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .cnt       (buf_cnt)
  );

  // Pop decisions and read credit. The byte leaving the buffer this cycle
  // frees its slot for the byte requested now, which sustains one byte per cycle.
  always_comb begin
    hdr           = hdr_t'(buf_head);
    buf_has       = (buf_cnt != 2'd0);
    valid_c       = (state == PAYLOAD) && buf_has;
    hdr_pop       = (state == HDR) && buf_has;
    xfer          = valid_c && out_if.out_ready;
    buf_pop       = hdr_pop || xfer;
    level         = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, buf_pop};
    fifo_read_req = !fifo_empty && (level < 3'd2);
  end

  // Output beat is the buffer head, framed by the packet state.
  always_comb begin
    out_if.out_valid = valid_c;
    out_if.out_data  = buf_head;
    out_if.out_sop   = valid_c && first;
    out_if.out_eop   = valid_c && (remaining == LEN_W'(1));
    out_if.out_port  = port_q;
  end

  // A request accepted now returns its byte in the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_read_req;
  end

  // Packet FSM: consume the header, then count payload transfers down to eop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HDR;
      first     <= 1'b0;
      remaining <= '0;
      port_q    <= '0;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      unique case (state)
        HDR: begin
          if (buf_has) begin
            port_q    <= hdr.port;
            remaining <= hdr.len;
            if (hdr.len == '0) begin
              drop_cnt <= drop_cnt + CNT_W'(1);
            end else begin
              state <= PAYLOAD;
              first <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            remaining <= remaining - LEN_W'(1);
            first     <= 1'b0;
            if (remaining == LEN_W'(1)) begin
              pkt_cnt <= pkt_cnt + CNT_W'(1);
              state   <= HDR;
            end
          end
        end
        default: state <= HDR;
      endcase
    end
  end
endmodule
